router_pkt_ctrl: RTL and testbench
==================================

Name: router_pkt_ctrl

Overview:
Input-side packet controller for the 1x3 router. It decodes the header address and sequences byte writes into one of three 9-bit-tagged output FIFOs. It generates the header-tag strobe, throttles the source with busy when the target FIFO is full, checks packet parity, and times out unread channels with per-channel soft resets.

Parameters:
TIMEOUT, 30, consecutive cycles a channel may stay valid-but-unread before soft_reset pulses
CNT_W, 5, width of each timeout counter (must hold TIMEOUT)

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  high for header and payload bytes; low on the parity byte
data_in  in  8  packet byte; header = {len[5:0], addr[1:0]}
fifo_full  in  3  full flags of FIFO 0..2
fifo_empty  in  3  empty flags of FIFO 0..2
read_enb  in  3  downstream read enables per FIFO
write_enb  out  3  one-hot FIFO write strobe
dout  out  8  byte presented to all FIFOs (registered)
lfd_state  out  1  high during LOAD_FIRST_DATA (FIFO registers it as the header tag)
busy  out  1  source must hold data_in and pkt_valid while high
vld_out  out  3  ~fifo_empty per channel
soft_reset  out  3  one-cycle per-channel flush pulse
err  out  1  parity mismatch on the last packet
parity_done  out  1  one-cycle pulse when parity has been checked

Behaviour:
- Reset (async, resetn=0): state=DECODE_ADDRESS. dout=0, write_enb=0, busy=0, lfd_state=0, soft_reset=0, err=0, parity_done=0. All counters, hold and parity registers are 0. Reset mid-packet discards the packet.
- Registers: addr_q[1:0], dout_q (wv_q = pending write), hold_q/hold_v/hold_par (one-byte skid), calc_par (running XOR), pkt_par.
- Write rule: write_enb[i] = wv_q & (addr_q==i) & ~fifo_full[i]. A write commits in any cycle where write_enb[i] is high. Otherwise dout_q is held.
- DECODE_ADDRESS (busy=0): on pkt_valid, latch addr_q, dout_q<=data_in, calc_par<=data_in, wv_q<=0.
  - addr==3 -> DROP.
  - fifo_empty[addr] -> LOAD_FIRST_DATA.
  - else -> WAIT_TILL_EMPTY.
- WAIT_TILL_EMPTY (busy=1): header is held in dout_q. When fifo_empty[addr_q] -> LOAD_FIRST_DATA.
- LOAD_FIRST_DATA (busy=1, lfd_state=1): wv_q<=1, so the header is written the next cycle, aligned with the FIFO's registered tag. -> LOAD_DATA. The header never stalls because the FIFO is empty.
- LOAD_DATA (busy=0): accept data_in every cycle and XOR it into calc_par if pkt_valid.
  - No stall (wv_q & fifo_full[addr_q] false): dout_q<=data_in, wv_q<=1.
  - Stall: hold_q<=data_in, hold_v<=1, hold_par<=~pkt_valid -> FIFO_FULL_STATE.
  - pkt_valid=0 without stall: byte is parity, pkt_par<=data_in -> CHECK_PARITY.
- FIFO_FULL_STATE (busy=1): wait until dout_q commits. Then dout_q<=hold_q, wv_q<=1, hold_v<=0 -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL (busy=1): stay while the presented byte is blocked. Once it commits:
  - hold_par=1 -> pkt_par<=byte -> CHECK_PARITY.
  - hold_par=0 -> LOAD_DATA, with wv_q<=0 after the commit.
- CHECK_PARITY (busy=1): wait until the parity write commits (wv_q<=0). Then err<=(calc_par!=pkt_par), parity_done pulses for 1 cycle -> DECODE_ADDRESS. err holds until the next CHECK_PARITY completes.
- DROP (busy=0): ignore bytes, no writes, until pkt_valid=0 (parity consumed) -> DECODE_ADDRESS. err is unchanged.
- Soft reset, per channel i:
  - cnt_i increments while vld_out[i] & ~read_enb[i]; it clears on read_enb[i] or ~vld_out[i].
  - When cnt_i reaches TIMEOUT-1: soft_reset[i]=1 for one cycle and cnt_i<=0.
  - If soft_reset[addr_q] fires in a packet state: clear wv_q and hold_v, then go to DROP if pkt_valid, else DECODE_ADDRESS.
- Simultaneous events: a FIFO full condition that clears in the same cycle a stall would be detected is not a stall (the full flag is sampled combinationally). A header arriving while parity_done pulses is a new packet (DECODE_ADDRESS is entered the next cycle).

Test Plan:
- Packet to addr 1, len 3, bytes 0x0D,0xA1,0xB2,0xC3, parity = XOR of all -> write_enb=3'b010 for 5 cycles, lfd_state high 1 cycle before the header write, err=0, parity_done one pulse.
- Same packet with the parity byte corrupted (XOR 0x01) -> all 5 bytes written, err=1 after CHECK_PARITY, err clears after the next good packet.
- Addr 2 with FIFO 2 non-empty at header -> busy=1 in WAIT_TILL_EMPTY. Drop fifo_empty[2] -> header written with lfd tag, then payload proceeds.
- fifo_full[0] asserted for 4 cycles mid-payload -> busy=1, no write_enb[0] while full, no byte lost or duplicated, order preserved. Repeat with the stall landing on the parity byte.
- Header addr 3 with len 2 -> no write_enb for 4 cycles, DROP exits on pkt_valid=0, next valid packet is accepted normally.
- FIFO 1 non-empty, read_enb[1]=0 for 30 cycles -> soft_reset[1] pulses exactly at cycle 30. A single read at cycle 29 restarts the count. Assert resetn=0 mid-payload -> all outputs 0 immediately.

Source files
------------

// File: rtl/router_pkt_ctrl.sv
// Input-side router controller: decodes the header, sequences bytes into FIFO 0..2, checks parity, times out stale channels.
// data_in reaches dout one cycle after acceptance; busy holds the source while a header waits or a stalled byte is parked.
module router_pkt_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic [7:0] dout,
    output logic       lfd_state,
    output logic       busy,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
    output logic       err,
    output logic       parity_done
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        CHECK_PARITY,
        DROP
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           addr_q, addr_d;
    logic [7:0]           dout_q, dout_d;
    logic [7:0]           hold_q, hold_d;
    logic [7:0]           calc_par_q, calc_par_d;
    logic [7:0]           pkt_par_q, pkt_par_d;
    logic                 wv_q, wv_d;
    logic                 hold_v_q, hold_v_d;
    logic                 hold_par_q, hold_par_d;
    logic                 err_q, err_d;
    logic                 pdone_q, pdone_d;
    logic [2:0][CNT_W-1:0] cnt_q;
    logic [3:0]           empty_pad, sr_pad;
    logic                 commit, stall, sr_hit, in_pkt;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            write_enb[i]  = wv_q && (addr_q == 2'(i)) && !fifo_full[i];
            soft_reset[i] = (cnt_q[i] == CNT_W'(TIMEOUT - 1));
        end
    end

    // Address 3 has no FIFO: padding keeps the dynamic index in range.
    assign empty_pad   = {1'b0, fifo_empty};
    assign sr_pad      = {1'b0, soft_reset};
    assign commit      = |write_enb;
    assign stall       = wv_q && !commit;
    assign sr_hit      = sr_pad[addr_q];
    assign in_pkt      = (state_q != DECODE_ADDRESS) && (state_q != DROP);
    assign vld_out     = ~fifo_empty;
    assign dout        = dout_q;
    assign err         = err_q;
    assign parity_done = pdone_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        wv_d       = wv_q;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        hold_par_d = hold_par_q;
        calc_par_d = calc_par_q;
        pkt_par_d  = pkt_par_q;
        err_d      = err_q;
        pdone_d    = 1'b0;
        busy       = 1'b0;
        lfd_state  = 1'b0;
        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    addr_d     = data_in[1:0];
                    dout_d     = data_in;
                    calc_par_d = data_in;
                    wv_d       = 1'b0;
                    if (data_in[1:0] == 2'd3)
                        state_d = DROP;
                    else if (empty_pad[data_in[1:0]])
                        state_d = LOAD_FIRST_DATA;
                    else
                        state_d = WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (empty_pad[addr_q])
                    state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: begin
                busy      = 1'b1;
                lfd_state = 1'b1;
                wv_d      = 1'b1;
                state_d   = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (pkt_valid)
                    calc_par_d = calc_par_q ^ data_in;
                if (stall) begin
                    hold_d     = data_in;
                    hold_v_d   = 1'b1;
                    hold_par_d = !pkt_valid;
                    state_d    = FIFO_FULL_STATE;
                end else begin
                    dout_d = data_in;
                    wv_d   = 1'b1;
                    if (!pkt_valid) begin
                        pkt_par_d = data_in;
                        state_d   = CHECK_PARITY;
                    end
                end
            end
            FIFO_FULL_STATE: begin
                busy = 1'b1;
                if (commit && hold_v_q) begin
                    dout_d   = hold_q;
                    wv_d     = 1'b1;
                    hold_v_d = 1'b0;
                    state_d  = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                busy = 1'b1;
                if (commit) begin
                    wv_d = 1'b0;
                    if (hold_par_q) begin
                        pkt_par_d = dout_q;
                        state_d   = CHECK_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
            end
            CHECK_PARITY: begin
                busy = 1'b1;
                // The parity byte may already be written when it arrived via the skid path.
                if (!wv_q || commit) begin
                    wv_d    = 1'b0;
                    err_d   = (calc_par_q != pkt_par_q);
                    pdone_d = 1'b1;
                    state_d = DECODE_ADDRESS;
                end
            end
            DROP: begin
                if (!pkt_valid)
                    state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        if (in_pkt && sr_hit) begin
            wv_d     = 1'b0;
            hold_v_d = 1'b0;
            state_d  = pkt_valid ? DROP : DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= DECODE_ADDRESS;
            addr_q     <= '0;
            dout_q     <= '0;
            hold_q     <= '0;
            calc_par_q <= '0;
            pkt_par_q  <= '0;
            wv_q       <= 1'b0;
            hold_v_q   <= 1'b0;
            hold_par_q <= 1'b0;
            err_q      <= 1'b0;
            pdone_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            hold_q     <= hold_d;
            calc_par_q <= calc_par_d;
            pkt_par_q  <= pkt_par_d;
            wv_q       <= wv_d;
            hold_v_q   <= hold_v_d;
            hold_par_q <= hold_par_d;
            err_q      <= err_d;
            pdone_q    <= pdone_d;
            for (int i = 0; i < 3; i++) begin
                if (!vld_out[i] || read_enb[i] || soft_reset[i])
                    cnt_q[i] <= '0;
                else
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Bench for router_pkt_ctrl: packet stimulus with an expected-write scoreboard drained by a write monitor.
module tb_router_pkt_ctrl;
    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full, fifo_empty, read_enb;
    logic [2:0] write_enb, vld_out, soft_reset;
    logic [7:0] dout;
    logic       lfd_state, busy, err, parity_done;

    router_pkt_ctrl #(.TIMEOUT(30), .CNT_W(5)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
        .write_enb(write_enb), .dout(dout), .lfd_state(lfd_state), .busy(busy),
        .vld_out(vld_out), .soft_reset(soft_reset), .err(err), .parity_done(parity_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] ch;
        logic       lfd;
        logic [7:0] dat;
    } wr_t;

    wr_t        sb_q[$];
    logic [7:0] pay [16];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_wr    = 0;
    int         busy_full = 0;
    logic       mon_en  = 1'b0;
    logic       prev_lfd = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Write monitor: every FIFO write must match the head of the scoreboard.
    always @(negedge clock) begin
        wr_t        e;
        logic [2:0] oh;
        if (mon_en && resetn) begin
            if (write_enb != 3'b000) begin
                n_wr++;
                check_eq("wr_vs_full", 32'(write_enb & fifo_full), 32'd0);
                if (sb_q.size() == 0) begin
                    check_eq("unexp_wr", 32'(write_enb), 32'd0);
                end else begin
                    e  = sb_q.pop_front();
                    oh = 3'b001 << e.ch;
                    check_eq("wr_ch", 32'(write_enb), 32'(oh));
                    check_eq("wr_dat", 32'(dout), 32'(e.dat));
                    check_eq("wr_lfd", 32'(prev_lfd), 32'(e.lfd));
                end
            end
            if (busy && fifo_full != 3'b000)
                busy_full++;
        end
        prev_lfd = lfd_state;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic v);
        int guard = 0;
        data_in   = b;
        pkt_valid = v;
        while (busy && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 200)
            check_eq("busy_tmo", 32'(busy), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic send_pkt(input logic [1:0] addr, input int len, input logic [7:0] corrupt,
                            input int stall_at, input bit push);
        logic [7:0] hdr, par, cur;
        logic       v;
        hdr = {6'(len), addr};
        par = hdr;
        for (int i = 0; i < len; i++) par ^= pay[i];
        par ^= corrupt;
        if (push && addr != 2'd3) begin
            sb_q.push_back('{ch: addr, lfd: 1'b1, dat: hdr});
            for (int i = 0; i < len; i++) sb_q.push_back('{ch: addr, lfd: 1'b0, dat: pay[i]});
            sb_q.push_back('{ch: addr, lfd: 1'b0, dat: par});
        end
        for (int i = 0; i <= len + 1; i++) begin
            if (i == 0) begin
                cur = hdr; v = 1'b1;
            end else if (i <= len) begin
                cur = pay[i-1]; v = 1'b1;
            end else begin
                cur = par; v = 1'b0;
            end
            if (i == stall_at) begin
                fifo_full = 3'b001;
                fork
                    begin
                        repeat (4) @(posedge clock);
                        #1 fifo_full = 3'b000;
                    end
                join_none
            end
            send_byte(cur, v);
        end
        data_in   = 8'h00;
        pkt_valid = 1'b0;
    endtask

    task automatic wait_pdone(input logic exp_err, input string tag);
        int n = 0;
        @(negedge clock);
        while (!parity_done && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_pdone"}, 32'(parity_done), 32'd1);
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        @(negedge clock);
        check_eq({tag, "_pdone_1cyc"}, 32'(parity_done), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        int cyc, wr0;
        bit hit;
        resetn     = 1'b0;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        read_enb   = 3'b000;
        repeat (2) @(negedge clock);
        check_eq("rst_outs", 32'({write_enb, dout, lfd_state, busy, soft_reset, err, parity_done}), 32'd0);
        check_eq("rst_vld", 32'(vld_out), 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        mon_en = 1'b1;

        // Basic packet to channel 1.
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        wr0 = n_wr;
        send_pkt(2'd1, 3, 8'h00, -1, 1'b1);
        wait_pdone(1'b0, "good1");
        check_eq("good1_nwr", 32'(n_wr - wr0), 32'd5);

        // Corrupted parity, then a clean packet clears err.
        wr0 = n_wr;
        send_pkt(2'd1, 3, 8'h01, -1, 1'b1);
        wait_pdone(1'b1, "bad1");
        check_eq("bad1_nwr", 32'(n_wr - wr0), 32'd5);
        pay[0] = 8'h5A; pay[1] = 8'h3C;
        send_pkt(2'd0, 2, 8'h00, -1, 1'b1);
        wait_pdone(1'b0, "good2");

        // Channel 2 not empty at header time.
        fifo_empty = 3'b011;
        pay[0] = 8'h11; pay[1] = 8'h22;
        fork
            send_pkt(2'd2, 2, 8'h00, -1, 1'b1);
            begin
                repeat (4) @(negedge clock);
                check_eq("wte_busy", 32'(busy), 32'd1);
                check_eq("wte_nowr", 32'(write_enb), 32'd0);
                check_eq("wte_vld", 32'(vld_out), 32'b100);
                @(posedge clock); #1;
                fifo_empty = 3'b111;
            end
        join
        wait_pdone(1'b0, "wte");

        // FIFO 0 full for 4 cycles mid-payload, then on the parity byte.
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        busy_full = 0;
        send_pkt(2'd0, 4, 8'h00, 2, 1'b1);
        wait_pdone(1'b0, "stall_pl");
        check_eq("stall_pl_busy", 32'(busy_full != 0), 32'd1);
        pay[0] = 8'hE1; pay[1] = 8'hE2; pay[2] = 8'hE3;
        busy_full = 0;
        send_pkt(2'd0, 3, 8'h00, 4, 1'b1);
        wait_pdone(1'b0, "stall_par");
        check_eq("stall_par_busy", 32'(busy_full != 0), 32'd1);

        // Address 3 is dropped; err keeps its previous value.
        wr0 = n_wr;
        pay[0] = 8'h77; pay[1] = 8'h88;
        send_pkt(2'd3, 2, 8'h00, -1, 1'b1);
        repeat (3) @(negedge clock);
        check_eq("drop_nowr", 32'(n_wr - wr0), 32'd0);
        check_eq("drop_err", 32'(err), 32'd0);
        check_eq("drop_idle", 32'(busy), 32'd0);
        @(posedge clock); #1;
        pay[0] = 8'h99; pay[1] = 8'hAA;
        send_pkt(2'd2, 2, 8'h00, -1, 1'b1);
        wait_pdone(1'b0, "after_drop");

        // Timeout on channel 1.
        fifo_empty = 3'b101;
        cyc = 0; hit = 0;
        while (!hit && cyc < 80) begin
            @(negedge clock); cyc++;
            if (soft_reset[1]) hit = 1;
        end
        check_eq("to_cycle", 32'(cyc), 32'd30);
        check_eq("to_only1", 32'(soft_reset), 32'b010);
        @(negedge clock);
        check_eq("to_1cyc", 32'(soft_reset), 32'd0);
        @(posedge clock); #1;
        fifo_empty = 3'b111;
        @(posedge clock); #1;
        fifo_empty = 3'b101;
        cyc = 0; hit = 0;
        while (!hit && cyc < 80) begin
            @(negedge clock); cyc++;
            if (cyc == 29) read_enb = 3'b010;
            else if (cyc == 30) read_enb = 3'b000;
            if (soft_reset[1]) hit = 1;
        end
        check_eq("to_restart", 32'(cyc), 32'd59);
        @(posedge clock); #1;
        fifo_empty = 3'b111;

        // Async reset mid-payload, right after a bad packet so err is set.
        pay[0] = 8'h10; pay[1] = 8'h20;
        send_pkt(2'd0, 2, 8'h40, -1, 1'b1);
        wait_pdone(1'b1, "bad2");
        mon_en = 1'b0;
        send_byte({6'd3, 2'd1}, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        check_eq("pre_rst_wr", 32'(write_enb), 32'b010);
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_outs", 32'({write_enb, dout, lfd_state, busy, soft_reset, err, parity_done}), 32'd0);
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        @(posedge clock); @(posedge clock); #1;
        resetn = 1'b1;
        mon_en = 1'b1;
        pay[0] = 8'hCA; pay[1] = 8'hFE; pay[2] = 8'h42;
        send_pkt(2'd2, 3, 8'h00, -1, 1'b1);
        wait_pdone(1'b0, "recover");

        repeat (3) @(negedge clock);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
